// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller.
//   state_t         : sequencer state encoding (RUN / MEM_WAIT)
//   NOP_REG_WRITE   : reg_write value loaded into MEM/WB on a bubble
//   NOP_MEM_TO_REG  : mem_to_reg value loaded into MEM/WB on a bubble
//   REG_ZERO        : hard-wired zero register, never a real hazard source
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic       NOP_REG_WRITE  = 1'b0;
    localparam logic [1:0] NOP_MEM_TO_REG = 2'b00;
    localparam logic [4:0] REG_ZERO       = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   id_rs, id_rt, id_uses_rt : source operands of the instruction in ID
//   ex_mem_read, ex_rd       : load flag and destination of the instruction in EX
//   load_use                 : ID needs a value the EX load has not produced yet
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    // A load into r0 writes nothing, so it can never feed a dependent instruction.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard and stall sequencer for the IF/ID/EX/MEM/WB pipeline.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt         : ID operand fields
//   ex_mem_read, ex_rd               : EX load information
//   branch_taken, jump               : control-flow redirects (EX / ID)
//   mem_req, mem_ready               : MEM-stage data memory handshake
//   pc_write, if_id_write            : load enables for PC and IF/ID
//   if_id_flush, id_ex_flush         : NOP insertion into IF/ID and ID/EX
//   id_ex_hold, ex_mem_hold          : freeze ID/EX and EX/MEM
//   mem_wb_bubble                    : MEM/WB loads NOP_REG_WRITE / NOP_MEM_TO_REG
//   mem_timeout                      : sticky memory-wait watchdog error
//   stall_cycles                     : saturating count of cycles with pc_write=0
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        load_use;
    logic        mem_wait;

    hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // An outstanding access stalls in either state; a same-cycle ready never waits.
    assign mem_wait = mem_req && !mem_ready;

    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if (mem_wait) begin
                // Whole front end frozen; EX/ID inputs stay stable, so redirects
                // are simply re-evaluated once memory answers.
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_hold    = 1'b1;
                ex_mem_hold   = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (branch_taken) begin
                // The ID instruction is wrong-path, so any load-use on it is moot.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end else if (jump) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (mem_wait) begin
                state <= MEM_WAIT;
                if (state == MEM_WAIT) begin
                    // Counter parks at its limit; the error flag then latches.
                    if (wait_cnt == WAIT_MAX) begin
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
            end else begin
                state    <= RUN;
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, branch_taken, jump, mem_req, mem_ready;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic             id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .id_ex_hold    (id_ex_hold),
        .ex_mem_hold   (ex_mem_hold),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_timeout   (mem_timeout),
        .stall_cycles  (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Reset state and outputs held low during reset
        settle();
        chk("rst_pc_write", pc_write, 0);
        chk("rst_if_id_write", if_id_write, 0);
        tick();
        chk("rst_stall", stall_cycles, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_state", dut.state, RUN);
        rst = 1'b0;

        // No hazard
        settle();
        chk("idle_pc_write", pc_write, 1);
        chk("idle_if_id_write", if_id_write, 1);
        chk("idle_id_ex_flush", id_ex_flush, 0);
        tick();

        // Load-use via rs
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        settle();
        chk("lu_rs_pc_write", pc_write, 0);
        chk("lu_rs_if_id_write", if_id_write, 0);
        chk("lu_rs_id_ex_flush", id_ex_flush, 1);
        tick();
        chk("lu_rs_stall", stall_cycles, 1);

        // Load into r0 is not a hazard
        ex_rd = 5'd0; id_rs = 5'd0;
        settle();
        chk("lu_r0_pc_write", pc_write, 1);
        chk("lu_r0_id_ex_flush", id_ex_flush, 0);
        tick();
        chk("lu_r0_stall", stall_cycles, 1);

        // Load-use via rt, only when rt is actually read
        ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
        settle();
        chk("lu_rt_pc_write", pc_write, 0);
        tick();
        chk("lu_rt_stall", stall_cycles, 2);
        id_uses_rt = 1'b0;
        settle();
        chk("lu_rt_unused_pc_write", pc_write, 1);
        tick();
        chk("lu_rt_unused_stall", stall_cycles, 2);

        // Branch overrides load-use
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
        settle();
        chk("br_if_id_flush", if_id_flush, 1);
        chk("br_id_ex_flush", id_ex_flush, 1);
        chk("br_pc_write", pc_write, 1);
        tick();
        chk("br_stall", stall_cycles, 2);

        // Jump alone
        clear_inputs();
        jump = 1'b1;
        settle();
        chk("jmp_if_id_flush", if_id_flush, 1);
        chk("jmp_id_ex_flush", id_ex_flush, 0);
        chk("jmp_pc_write", pc_write, 1);
        tick();

        // Memory wait for 3 cycles, redirects present but suppressed
        clear_inputs();
        do_reset();
        mem_req = 1'b1; branch_taken = 1'b1; jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_pc_write", pc_write, 0);
            chk("mw_id_ex_hold", id_ex_hold, 1);
            chk("mw_ex_mem_hold", ex_mem_hold, 1);
            chk("mw_bubble", mem_wb_bubble, 1);
            chk("mw_if_id_flush", if_id_flush, 0);
            tick();
            chk("mw_state", dut.state, MEM_WAIT);
        end
        branch_taken = 1'b0; jump = 1'b0; mem_ready = 1'b1;
        settle();
        chk("mw_rel_pc_write", pc_write, 1);
        chk("mw_rel_ex_mem_hold", ex_mem_hold, 0);
        tick();
        chk("mw_rel_state", dut.state, RUN);
        chk("mw_rel_stall", stall_cycles, 3);
        chk("mw_rel_timeout", mem_timeout, 0);

        // Watchdog: 1 RUN stall cycle plus 4 MEM_WAIT cycles
        clear_inputs();
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wd_timeout", mem_timeout, (i == 4) ? 1 : 0);
        end
        mem_ready = 1'b1;
        tick();
        chk("wd_sticky_ready", mem_timeout, 1);
        mem_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("wd_sticky_idle", mem_timeout, 1);
        chk("wd_stall", stall_cycles, 5);

        // Reset in the middle of a wait
        mem_req = 1'b1;
        tick();
        tick();
        chk("rmw_state_wait", dut.state, MEM_WAIT);
        rst = 1'b1;
        settle();
        chk("rmw_pc_write", pc_write, 0);
        chk("rmw_ex_mem_hold", ex_mem_hold, 0);
        tick();
        chk("rmw_state", dut.state, RUN);
        chk("rmw_stall", stall_cycles, 0);
        chk("rmw_timeout", mem_timeout, 0);
        rst = 1'b0; mem_req = 1'b0;
        settle();
        chk("rmw_after_pc_write", pc_write, 1);
        chk("rmw_after_id_ex_hold", id_ex_hold, 0);
        tick();

        // Stall counter saturation
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_14", stall_cycles, 14);
        end
        chk("sat_20", stall_cycles, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the write-enable, flush and hold controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, including their control-bit registers.
- Resolves load-use hazards, taken-branch and jump flushes, and multi-cycle data-memory waits.
- Also keeps a memory-wait watchdog and a stall performance counter.

Parameters:
- TIMEOUT, 64: maximum number of MEM_WAIT cycles before mem_timeout is raised; legal range 2..65535.
- CNT_W, 16: width of the stall_cycles performance counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- branch_taken  in  1  branch resolved taken in EX.
- jump  in  1  jump decoded in ID.
- mem_req  in  1  the MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX control bits, inserting a bubble.
- id_ex_hold  out  1  ID/EX holds its value.
- ex_mem_hold  out  1  EX/MEM holds its value.
- mem_wb_bubble  out  1  MEM/WB loads reg_write=0 and mem_to_reg=2'b00.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- Reset is synchronous and active-high on clk.
  - While rst=1: state<=RUN, wait_cnt<=0, mem_timeout<=0, stall_cycles<=0.
  - Combinational outputs during rst: pc_write=0, if_id_write=0, all flush, hold and bubble outputs=0.
  - A reset asserted during MEM_WAIT abandons the wait; no output is held after rst deasserts.
- State: 2-state FSM {RUN, MEM_WAIT}, registered. Outputs are Mealy, derived from state and the current inputs.
- Default (no hazard): pc_write=1, if_id_write=1, all other control outputs=0.
- Priority, highest first:
  1. Memory wait.
  2. Branch taken.
  3. Load-use.
  4. Jump.
- Memory wait: mem_req=1 and mem_ready=0, in either state.
  - Outputs: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, mem_wb_bubble=1.
  - Flushes are suppressed; branch_taken and jump are ignored because EX and ID are frozen and their inputs stay stable.
  - Next state = MEM_WAIT.
- Release: in MEM_WAIT with mem_ready=1, or with mem_req=0.
  - The normal priority rules (2-4) apply in that same cycle.
  - Next state = RUN, wait_cnt<=0.
  - A single-cycle access (mem_ready=1 in the request cycle) never enters MEM_WAIT.
- Branch taken: pc_write=1, if_id_flush=1, id_ex_flush=1. Overrides any load-use condition, since that instruction is wrong-path.
- Load-use: condition is ex_mem_read=1, ex_rd!=0, and either ex_rd==id_rs or (id_uses_rt=1 and ex_rd==id_rt).
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Lasts exactly one cycle; the condition clears naturally once the load advances to MEM.
- Jump (with no higher-priority event): if_id_flush=1, pc_write=1.
- Watchdog:
  - wait_cnt increments each MEM_WAIT cycle, saturating at TIMEOUT-1.
  - When wait_cnt==TIMEOUT-1 and mem_ready=0, mem_timeout<=1.
  - mem_timeout is sticky until rst; the pipeline stays frozen.
- stall_cycles:
  - Increments on every non-reset cycle with pc_write=0.
  - Saturates at all-ones and never wraps.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding: RUN=1'b0, MEM_WAIT=1'b1.
  - NOP/bubble control constants: reg_write=1'b0, mem_to_reg=2'b00.
  - REG_ZERO=5'd0.
- Sub-module: hazard_detect (combinational load-use compare, output load_use). All sequencing stays in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5'd8, id_rs=5'd8 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cycles 0->1. Repeat with ex_rd=0 -> no stall.
- Branch with load-use: branch_taken=1 with a load-use present -> if_id_flush=1, id_ex_flush=1, pc_write=1, stall_cycles unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> 3 cycles of pc_write=0, ex_mem_hold=1, mem_wb_bubble=1; release cycle has pc_write=1, state=RUN; stall_cycles=3.
- Watchdog: TIMEOUT=4, mem_ready held 0 -> mem_timeout rises after the 4th MEM_WAIT cycle and stays 1 after mem_ready=1, until rst.
- Reset mid-wait: rst=1 during MEM_WAIT -> next cycle state=RUN, stall_cycles=0, mem_timeout=0; with mem_req=0 after reset, pc_write=1.
- Saturation: CNT_W=4, stall 20 consecutive cycles -> stall_cycles=4'hF, no wrap.
